mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter sitting on the pipelined processor's data-memory bus inside `Wrapper`. It decodes processor stores to a fixed TX address, buffers the low byte of each store in a small FIFO, and serialises the bytes as 8N1 frames on a single `tx` line. This gives programs a debug/console output path to the board or to the simulation harness.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per serial bit (50 MHz / 115200); legal range ≥ 2
- `TX_ADDR`, 32'h0000_1000, word address for data stores (write-only)
- `STAT_ADDR`, 32'h0000_1004, word address for the status read
- `FIFO_DEPTH`, 8, byte entries; power of two, ≥ 2
- `clock` in 1, system clock, rising-edge
- `reset` in 1, synchronous, active-high
- `mem_we` in 1, processor store strobe, one cycle per store
- `mem_addr` in 32, processor data address
- `mem_wdata` in 32, store data; only bits [7:0] are used
- `stat_rdata` out 32, combinational: {28'b0, overflow, busy, full, empty} when `mem_addr == STAT_ADDR`, else 0
- `tx` out 1, serial line, idle high
- `tx_busy` out 1, high while a frame is on the line

## Operation
- Push: when `mem_we && mem_addr == TX_ADDR && !full`, `mem_wdata[7:0]` enters the FIFO at the next edge.
- Push while `full`: the byte is dropped and sticky `overflow` is set. `overflow` clears only on reset.
- `full` is evaluated before the edge. A push and a pop in the same cycle while full still drops the push.
- FSM states are IDLE, START, DATA, STOP, (PARITY).
- IDLE: if the FIFO is non-empty, pop into the shift register and go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each. A 3-bit index counts bits.
- STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- IDLE always lasts at least one cycle, so frames are separated by exactly one clock when the FIFO is non-empty.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. State and bit advance on wrap.
- `tx_busy` = (state != IDLE).
- Status `busy` = `tx_busy`. Status `full` and `empty` come from the FIFO occupancy count (log2(FIFO_DEPTH)+1 bits).
- Stores to any other address are ignored. Reads never side-effect.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, FSM=IDLE, baud counter=0, FIFO count=0 (`empty`=1, `full`=0), `overflow`=0, `stat_rdata` reflects those.
- Reset asserted mid-frame aborts the frame. `tx` returns high at the next edge, and buffered bytes are discarded.
- Latency: store in cycle n → FIFO count=1 after edge n → pop and `tx` falls after edge n+1.
- Frame length is 10·CLKS_PER_BIT cycles (11· with parity).
- Back-to-back frame period is frame length + 1.
- Pointers wrap modulo FIFO_DEPTH. Push to an empty FIFO and pop in the same cycle cannot occur, because the pop requires non-empty pre-edge.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is inserted between DATA and STOP and sends even parity (XOR of the 8 data bits) for one bit time.
- `UART_TX_PARITY_EN` undefined: PARITY logic is absent and frames are 8N1.

## Structure
- Package `uart_pkg`: FSM state enum, default `TX_ADDR`/`STAT_ADDR` constants, status bit-index constants.
- Sub-module `sync_fifo` (parameterised width/depth; push, pop, dout, full, empty, count).
- The FSM, baud counter, and address decode stay in `mmio_uart_tx`.

## Test plan
- Reset, then idle 50 cycles → `tx`=1, `tx_busy`=0, status reads 32'h1.
- CLKS_PER_BIT=4; store 0x55 to TX_ADDR → `tx` low 4 cycles starting one cycle after the store, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high. `tx_busy` is high for 40 cycles.
- Stores 0xA5, 0x3C back-to-back → two frames, with exactly one idle cycle between the STOP end of frame 1 and the START of frame 2. Sampled bytes match in order.
- With `tx` busy, store 9 bytes → bytes 1–8 transmitted, byte 9 dropped. Status `full`=1 then `overflow`=1 (read 32'hE while full and sending); `overflow` stays set after drain (32'h9).
- Assert reset for one cycle during DATA bit 3 → `tx`=1, `tx_busy`=0, FIFO empty at the next edge. No further frame appears.
- With `UART_TX_PARITY_EN`, store 0x07 → 11-bit frame with parity bit 1. Store 0x03 → parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the MMIO UART transmitter
//
// Purpose: FSM state encoding, default bus addresses, status-word bit
// positions and the parity helper used by mmio_uart_tx.
// Ports: none (package).

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam logic [31:0] UART_TX_ADDR_DEF   = 32'h0000_1000;
  localparam logic [31:0] UART_STAT_ADDR_DEF = 32'h0000_1004;

  // Status word layout: {28'b0, overflow, busy, full, empty}
  localparam int STAT_EMPTY_BIT    = 0;
  localparam int STAT_FULL_BIT     = 1;
  localparam int STAT_BUSY_BIT     = 2;
  localparam int STAT_OVERFLOW_BIT = 3;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
//
// Purpose: buffers bytes between the bus decode and the serialiser.
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   push, din           - write strobe and data (ignored while full)
//   pop                 - read strobe (ignored while empty); dout is show-ahead
//   dout                - entry at the read pointer
//   full, empty, count  - occupancy flags and count (0..DEPTH)

module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage kept out of the reset branch so it maps onto plain registers/RAM.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == (AW + 1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter on the data-memory bus
//
// Purpose: decodes stores to TX_ADDR, buffers the low byte in a FIFO and
// sends each byte as an 8N1 frame (8E1 when UART_TX_PARITY_EN is defined,
// inserting an even-parity bit between the data bits and the stop bit).
// Ports:
//   clock, reset         - rising-edge clock, synchronous active-high reset
//   mem_we               - processor store strobe, one cycle per store
//   mem_addr, mem_wdata  - store address and data (only wdata[7:0] used)
//   stat_rdata           - {28'b0, overflow, busy, full, empty} at STAT_ADDR
//   tx                   - serial line, idle high
//   tx_busy              - high while a frame is on the line

module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [31:0] TX_ADDR      = UART_TX_ADDR_DEF,
  parameter logic [31:0] STAT_ADDR    = UART_STAT_ADDR_DEF,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] stat_rdata,
  output logic        tx,
  output logic        tx_busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  uart_state_t       r_state;
  uart_state_t       w_state_nxt;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_overflow;

  logic              w_push_req;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [7:0]        w_fifo_dout;
  logic [CNT_W-1:0]  w_count;
  logic              w_baud_wrap;
  logic              w_tx;
  logic [31:0]       w_status;
  logic              w_unused;

  // Address decode: a store to TX_ADDR is accepted only if there is room,
  // using the pre-edge full flag even when a pop happens in the same cycle.
  assign w_push_req = mem_we && (mem_addr == TX_ADDR);
  assign w_push     = w_push_req && !w_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .din   (mem_wdata[7:0]),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign w_baud_wrap = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_tx = 1'b0;
        if (w_baud_wrap) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        w_tx = r_shift[r_bit_idx];
        if (w_baud_wrap && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          w_state_nxt = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        w_tx = even_parity(r_shift);
        if (w_baud_wrap) begin
          w_state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        w_tx = 1'b1;
        if (w_baud_wrap) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Baud counter is held at zero in IDLE so START always gets a full bit time.
  // The bit index is cleared outside DATA and wraps 7->0 naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_shift <= w_fifo_dout;
      end
      if ((r_state == ST_IDLE) || w_baud_wrap) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + 1'b1;
      end
      if (r_state != ST_DATA) begin
        r_bit_idx <= '0;
      end else if (w_baud_wrap) begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end
      if (w_push_req && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign tx      = w_tx;
  assign tx_busy = (r_state != ST_IDLE);

  always_comb begin
    w_status                    = '0;
    w_status[STAT_EMPTY_BIT]    = w_empty;
    w_status[STAT_FULL_BIT]     = w_full;
    w_status[STAT_BUSY_BIT]     = tx_busy;
    w_status[STAT_OVERFLOW_BIT] = r_overflow;
  end

  assign stat_rdata = (mem_addr == STAT_ADDR) ? w_status : 32'h0;

  // Upper store-data bits and the raw occupancy count are intentionally unused.
  assign w_unused = &{1'b0, mem_wdata[31:8], w_count};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx

module tb_mmio_uart_tx;

  localparam int          CPB       = 4;
  localparam logic [31:0] A_TX      = 32'h0000_1000;
  localparam logic [31:0] A_STAT    = 32'h0000_1004;
`ifdef UART_TX_PARITY_EN
  localparam int          FRAME_BITS = 11;
`else
  localparam int          FRAME_BITS = 10;
`endif

  logic        clock;
  logic        reset;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] stat_rdata;
  logic        tx;
  logic        tx_busy;

  int total;
  int bad;
  logic seen;
  logic [7:0] ob [8];

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .TX_ADDR      (A_TX),
    .STAT_ADDR    (A_STAT),
    .FIFO_DEPTH   (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .stat_rdata (stat_rdata),
    .tx         (tx),
    .tx_busy    (tx_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one store at the current negedge; returns at the next negedge.
  task automatic store(input logic [31:0] addr, input logic [7:0] d);
    mem_we    = 1'b1;
    mem_addr  = addr;
    mem_wdata = {24'hABCDEF, d};
    @(negedge clock);
    mem_we    = 1'b0;
    mem_addr  = A_STAT;
    mem_wdata = 32'h0;
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    mem_addr = A_STAT;
    #1;
    check(tag, stat_rdata, exp);
  endtask

  // Entered at the negedge of frame cycle 0; ends at the idle cycle after STOP.
  task automatic check_frame(input logic [7:0] b, input string tag);
    for (int i = 0; i < FRAME_BITS * CPB; i++) begin
      int   bitn;
      logic e;
      bitn = i / CPB;
      if (bitn == 0)                           e = 1'b0;
      else if (bitn <= 8)                      e = b[bitn-1];
      else if (bitn == 9 && FRAME_BITS == 11)  e = ^b;
      else                                     e = 1'b1;
      check($sformatf("%s tx c%0d", tag, i), {31'b0, tx}, {31'b0, e});
      check($sformatf("%s busy c%0d", tag, i), {31'b0, tx_busy}, 32'h1);
      @(negedge clock);
    end
    check($sformatf("%s idle tx", tag), {31'b0, tx}, 32'h1);
    check($sformatf("%s idle busy", tag), {31'b0, tx_busy}, 32'h0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    mem_we    = 1'b0;
    mem_addr  = A_STAT;
    mem_wdata = 32'h0;
    ob = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (50) @(negedge clock);
    check("reset tx", {31'b0, tx}, 32'h1);
    check("reset busy", {31'b0, tx_busy}, 32'h0);
    read_status("reset status", 32'h1);

    store(32'h0000_1008, 8'h77);
    repeat (5) @(negedge clock);
    check("other addr busy", {31'b0, tx_busy}, 32'h0);
    read_status("other addr status", 32'h1);
    mem_addr = 32'h0000_1000;
    #1;
    check("status at non-stat addr", stat_rdata, 32'h0);

    store(A_TX, 8'h55);
    check("latency tx still high", {31'b0, tx}, 32'h1);
    check("latency busy low", {31'b0, tx_busy}, 32'h0);
    read_status("one queued", 32'h0);
    @(negedge clock);
    check_frame(8'h55, "f55");

    store(A_TX, 8'hA5);
    store(A_TX, 8'h3C);
    check_frame(8'hA5, "fA5");
    @(negedge clock);
    check_frame(8'h3C, "f3C");
    repeat (5) @(negedge clock);

    store(A_TX, 8'hC3);
    repeat (2) @(negedge clock);
    for (int k = 0; k < 8; k++) store(A_TX, ob[k]);
    read_status("full busy", 32'h6);
    store(A_TX, 8'h99);
    read_status("full busy overflow", 32'hE);
    for (int i = 0; i < 100 && tx_busy; i++) @(negedge clock);
    check("wait idle after C3", {31'b0, tx_busy}, 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check_frame(ob[k], $sformatf("ovf%0d", k));
    end
    repeat (10) @(negedge clock);
    check("drained busy", {31'b0, tx_busy}, 32'h0);
    read_status("drained overflow sticky", 32'h9);

    store(A_TX, 8'h5A);
    store(A_TX, 8'h33);
    repeat (17) @(negedge clock);
    check("mid bit3 tx", {31'b0, tx}, 32'h1);
    check("mid bit3 busy", {31'b0, tx_busy}, 32'h1);
    reset = 1'b1;
    @(negedge clock);
    check("abort tx", {31'b0, tx}, 32'h1);
    check("abort busy", {31'b0, tx_busy}, 32'h0);
    read_status("abort status", 32'h1);
    reset = 1'b0;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clock);
      if (tx_busy !== 1'b0 || tx !== 1'b1) seen = 1'b1;
    end
    check("no frame after abort", {31'b0, seen}, 32'h0);

`ifdef UART_TX_PARITY_EN
    store(A_TX, 8'h07);
    @(negedge clock);
    check_frame(8'h07, "par07");
    store(A_TX, 8'h03);
    @(negedge clock);
    check_frame(8'h03, "par03");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
